// File: rtl/dmem_pkg.sv
// Shared address-decode constants and STATUS layout for the data-side responder.
// Offsets are word indices taken from ALUResult[4:2].
package dmem_pkg;

  localparam logic [3:0] RAM_REGION   = 4'h0;
  localparam logic [3:0] MMIO_REGION  = 4'h4;

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_TXDATA   = 3'd4;

  localparam int ST_IRQ    = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_CNT_LO = 4;

  localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO; push visible at the head one cycle later, pop on the edge.
// Push while full is dropped and flagged on overflow_o, regardless of a same-cycle pop.
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign overflow_o = push_i & full_o;
  // Storage is not reset, so mask the head while empty.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational loads, edge-committed stores, RAM + timer + console TX MMIO.
// Console output is valid/ready; tx_valid depends only on FIFO state, never on tx_ready.
import dmem_pkg::*;

module data_mem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram_q [RAM_WORDS];
  logic [63:0]   mtime_q, mtime_d;
  logic [31:0]   mtimecmp_q, mtimecmp_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;

  logic          ram_sel, mmio_sel;
  logic [AW-1:0] ram_idx;
  logic [2:0]    mmio_off;
  logic          wr_cmp, wr_status, wr_tx;
  logic          fifo_full, fifo_empty, fifo_push_ovf;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;
  logic          unused_addr;

  assign ram_sel   = (ALUResult[31:28] == RAM_REGION);
  assign mmio_sel  = (ALUResult[31:28] == MMIO_REGION);
  assign ram_idx   = ALUResult[AW+1:2];
  assign mmio_off  = ALUResult[4:2];
  // Upper RAM bits alias and byte-lane bits are ignored.
  assign unused_addr = ^ALUResult[27:0];

  assign wr_cmp    = MemWrite & mmio_sel & (mmio_off == OFF_MTIMECMP);
  assign wr_status = MemWrite & mmio_sel & (mmio_off == OFF_STATUS);
  assign wr_tx     = MemWrite & mmio_sel & (mmio_off == OFF_TXDATA);

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (reset),
    .push_i     (wr_tx),
    .push_dat_i (WriteData[7:0]),
    .pop_i      (tx_valid & tx_ready),
    .head_dat_o (tx_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (fifo_push_ovf)
  );

  assign tx_valid  = ~fifo_empty;
  assign timer_irq = irq_q;

  always_comb begin
    status                   = '0;
    status[ST_IRQ]           = irq_q;
    status[ST_FULL]          = fifo_full;
    status[ST_EMPTY]         = fifo_empty;
    status[ST_OVF]           = ovf_q;
    status[ST_CNT_LO +: 4]   = 4'(fifo_count);
  end

  always_comb begin
    ReadData = '0;
    if (ram_sel) begin
      ReadData = ram_q[ram_idx];
    end else if (mmio_sel) begin
      case (mmio_off)
        OFF_MTIME_LO: ReadData = mtime_q[31:0];
        OFF_MTIME_HI: ReadData = mtime_q[63:32];
        OFF_MTIMECMP: ReadData = mtimecmp_q;
        OFF_STATUS:   ReadData = status;
        default:      ReadData = '0;
      endcase
    end
  end

  // Set terms are OR-ed after the W1C mask so a same-cycle set always wins.
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = wr_cmp ? WriteData : mtimecmp_q;
    irq_d      = (mtime_q[31:0] == mtimecmp_q) | (irq_q & ~(wr_status & WriteData[ST_IRQ]));
    ovf_d      = fifo_push_ovf | (ovf_q & ~(wr_status & WriteData[ST_OVF]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (MemWrite && ram_sel) ram_q[ram_idx] <= WriteData;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed stimulus feeding an expectation queue; a negedge monitor pops and compares.
// Console bytes are checked against a separate queue whenever a pop is presented.
module tb_data_mem_responder;

  localparam logic [31:0] A_MTIME_LO = 32'h4000_0000;
  localparam logic [31:0] A_MTIME_HI = 32'h4000_0004;
  localparam logic [31:0] A_MTIMECMP = 32'h4000_0008;
  localparam logic [31:0] A_STATUS   = 32'h4000_000C;
  localparam logic [31:0] A_TXDATA   = 32'h4000_0010;
  localparam logic [31:0] A_IDLE     = 32'h1000_0000;

  localparam int K_RDATA = 0;
  localparam int K_IRQ   = 1;
  localparam int K_TXVLD = 2;
  localparam int K_TXDAT = 3;
  localparam int K_TXQ   = 4;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  logic        chk_vld;
  exp_t        exp_q[$];
  logic [7:0]  tx_exp_q[$];
  int          n_checks;
  int          n_fail;
  int          cyc;

  data_mem_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; equals the expected mtime value.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    logic [7:0]  tx_exp;
    if (chk_vld) begin
      n_checks = n_checks + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard_underflow: check presented with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          K_RDATA: act = ReadData;
          K_IRQ:   act = {31'b0, timer_irq};
          K_TXVLD: act = {31'b0, tx_valid};
          K_TXDAT: act = {24'b0, tx_data};
          default: act = 32'(tx_exp_q.size());
        endcase
        if (act !== e.val) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
        end
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      n_checks = n_checks + 1;
      if (tx_exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL tx_unexpected: got byte 0x%02h with nothing expected", tx_data);
      end else begin
        tx_exp = tx_exp_q.pop_front();
        if (tx_data !== tx_exp) begin
          n_fail = n_fail + 1;
          $display("FAIL tx_order: got 0x%02h expected 0x%02h", tx_data, tx_exp);
        end
      end
    end
  end

  // One bus cycle; an optional expectation is sampled by the monitor in this cycle.
  task automatic op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                    input int kind, input logic [31:0] ev, input string nm);
    exp_t e;
    MemWrite  = we;
    ALUResult = addr;
    WriteData = wd;
    if (kind >= 0) begin
      e.name = nm;
      e.kind = kind;
      e.val  = ev;
      exp_q.push_back(e);
      chk_vld = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_vld  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    op(1'b1, addr, wd, -1, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] ev, input string nm);
    op(1'b0, addr, 32'h0, K_RDATA, ev, nm);
  endtask

  task automatic chk(input int kind, input logic [31:0] ev, input string nm);
    op(1'b0, A_IDLE, 32'h0, kind, ev, nm);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_exp_q.push_back(b);
    wr(A_TXDATA, {24'h0, b});
  endtask

  task automatic idle_to(input int n);
    for (int i = 0; i < 200 && cyc < n; i++) op(1'b0, A_IDLE, 32'h0, -1, 32'h0, "");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    chk_vld   = 1'b0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = A_IDLE;
    WriteData = 32'h0;
    tx_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(K_IRQ,   32'h0,         "rst_irq");
    chk(K_TXVLD, 32'h0,         "rst_tx_valid");
    rd(A_MTIME_LO, 32'h0,       "rst_mtime_lo");
    rd(A_MTIMECMP, 32'hFFFF_FFFF, "rst_mtimecmp");
    rd(A_STATUS,   32'h0000_0004, "rst_status");
    reset = 1'b0;

    // Cycle n after release has mtime == n.
    wr(A_MTIMECMP, 32'd20);                            // c0
    rd(A_MTIME_LO, 32'd1,  "mtime_c1");                // c1
    rd(A_MTIME_LO, 32'd2,  "mtime_c2");                // c2
    rd(A_MTIMECMP, 32'd20, "mtimecmp_rb");             // c3
    rd(A_STATUS,   32'h4,  "status_idle");             // c4
    wr(32'h0000_0010, 32'hDEAD_BEEF);                  // c5
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_rt");        // c6
    rd(32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");     // c7
    rd(32'h8000_0000, 32'h0, "unmapped_rd");           // c8
    rd(A_MTIME_HI, 32'h0, "mtime_hi");                 // c9
    wr(32'h8000_0010, 32'h1234_5678);                  // c10
    rd(32'h4000_0014, 32'h0, "reserved_rd");           // c11
    rd(A_TXDATA, 32'h0, "txdata_rd0");                 // c12
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_after_unmapped_wr"); // c13

    idle_to(20);
    chk(K_IRQ, 32'h0, "irq_before_match");             // c20
    chk(K_IRQ, 32'h1, "irq_after_match");              // c21
    rd(A_STATUS, 32'h5, "status_irq");                 // c22
    op(1'b1, A_STATUS, 32'h1, K_IRQ, 32'h1, "irq_held"); // c23 clear
    chk(K_IRQ, 32'h0, "irq_cleared");                  // c24
    wr(A_MTIMECMP, 32'd28);                            // c25
    idle_to(28);
    chk(K_IRQ, 32'h0, "irq_pre_28");                   // c28
    op(1'b1, A_MTIMECMP, 32'd32, K_IRQ, 32'h1, "irq_at_29"); // c29
    idle_to(32);
    op(1'b1, A_STATUS, 32'h1, K_IRQ, 32'h1, "irq_c32"); // c32 set+clear
    chk(K_IRQ, 32'h1, "irq_set_wins");                 // c33
    wr(A_STATUS, 32'h1);                               // c34
    chk(K_IRQ, 32'h0, "irq_cleared2");                 // c35

    // Fill, overflow, drain.
    push_tx(8'h41);
    push_tx(8'h42);
    push_tx(8'h43);
    push_tx(8'h44);
    rd(A_STATUS, 32'h42, "status_full");
    wr(A_TXDATA, 32'h45);
    rd(A_STATUS, 32'h4A, "status_overflow");
    tx_ready = 1'b1;
    repeat (4) chk(K_TXVLD, 32'h1, "tx_valid_draining");
    chk(K_TXVLD, 32'h0, "tx_valid_drained");
    rd(A_STATUS, 32'h0C, "status_drained");
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, 32'h04, "status_ovf_cleared");

    // Push into empty with ready high: no same-cycle pop.
    tx_exp_q.push_back(8'h81);
    op(1'b1, A_TXDATA, 32'h81, K_TXVLD, 32'h0, "push_empty_no_valid");
    chk(K_TXVLD, 32'h1, "push_empty_valid_next");
    chk(K_TXVLD, 32'h0, "push_empty_popped");
    tx_ready = 1'b0;

    // Concurrent push/pop with two entries held.
    push_tx(8'h61);
    push_tx(8'h62);
    tx_ready = 1'b1;
    for (int v = 8'h51; v <= 8'h55; v++) begin
      tx_exp_q.push_back(8'(v));
      op(1'b1, A_TXDATA, 32'(v), K_RDATA, 32'h0, "txdata_reads0");
    end
    tx_ready = 1'b0;
    rd(A_STATUS, 32'h20, "status_count2");
    push_tx(8'h71);
    push_tx(8'h72);
    rd(A_STATUS, 32'h42, "status_full2");
    tx_ready = 1'b1;
    wr(A_TXDATA, 32'h73);
    tx_ready = 1'b0;
    rd(A_STATUS, 32'h38, "status_full_pop_ovf");

    // Arm an irq, then reset mid-cycle with three bytes queued.
    wr(A_MTIMECMP, 32'(cyc + 2));
    chk(K_IRQ, 32'h0, "irq_arm_a");
    chk(K_IRQ, 32'h0, "irq_arm_b");
    chk(K_IRQ, 32'h1, "irq_armed");
    chk(K_TXVLD, 32'h1, "tx_valid_pre_reset");
    #2;
    reset = 1'b1;
    tx_exp_q.delete();
    chk(K_TXVLD, 32'h0, "async_rst_tx_valid");
    chk(K_IRQ,   32'h0, "async_rst_irq");
    chk(K_TXDAT, 32'h0, "async_rst_tx_data");
    rd(A_MTIME_LO, 32'h0, "async_rst_mtime");
    rd(A_MTIMECMP, 32'hFFFF_FFFF, "async_rst_mtimecmp");
    rd(A_STATUS,   32'h4, "async_rst_status");
    rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_survives_reset");
    reset = 1'b0;
    chk(K_IRQ, 32'h0, "post_rst_irq");
    rd(A_MTIME_LO, 32'd1, "post_rst_mtime");
    chk(K_TXQ, 32'h0, "tx_bytes_outstanding");

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-side responder for the single-cycle RV32 core. It serves the core's data-memory initiator signals: MemWrite, ALUResult as address, WriteData, and it returns ReadData.
- It contains a word-addressed data RAM and a small MMIO region: a 64-bit free-running timer with compare interrupt, and a console TX FIFO with a valid/ready output.
- Reads are combinational so the core completes loads in the same cycle. Writes commit on the rising clock edge.

Parameters:
- RAM_WORDS, 64: data RAM depth in 32-bit words; power of 2.
- FIFO_DEPTH, 4: console TX FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWrite  in  1  write strobe from the core.
- ALUResult  in  32  byte address from the core; bits [1:0] ignored.
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from ALUResult and current state.
- tx_data  out  8  byte at the FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts a byte; a pop occurs when tx_valid & tx_ready at the edge.
- timer_irq  out  1  mirrors STATUS.irq_pending.

Behaviour:
- Decode, on ALUResult[31:28]:
  - 0x0 selects RAM; index = ALUResult[log2(RAM_WORDS)+1:2], upper bits ignored, so addresses alias.
  - 0x4 selects MMIO; offset = ALUResult[4:2].
  - Any other value is unmapped: reads return 0, writes are ignored.
- MMIO map (word offsets):
  - 0x00 MTIME_LO (RO).
  - 0x04 MTIME_HI (RO).
  - 0x08 MTIMECMP (RW).
  - 0x0C STATUS.
  - 0x10 TXDATA (WO, reads 0).
  - 0x14–0x1C reserved (read 0).
- STATUS bits:
  - [0] irq_pending (W1C).
  - [1] fifo_full (RO).
  - [2] fifo_empty (RO).
  - [3] tx_overflow (sticky, W1C).
  - [7:4] fifo count (RO).
  - Remaining bits read 0.
- Writes: take effect at the rising edge where MemWrite=1. A RAM write stores WriteData to the indexed word. Writes to RO registers are ignored.
- A load after a store to the same address, in the next cycle, returns the new value.
- Timer:
  - mtime increments by 1 every cycle and wraps from 2^64-1 to 0.
  - MTIME_LO and MTIME_HI read live values. No snapshot is taken; software re-reads HI to detect a carry.
- Compare:
  - irq_pending sets at the edge where mtime[31:0] == MTIMECMP, evaluated on pre-increment mtime.
  - Writing 1 to STATUS[0] clears it.
  - If set and clear occur in the same cycle, set wins.
  - A write to MTIMECMP takes effect for compares from the next cycle.
- TXDATA write pushes WriteData[7:0]:
  - Fullness is evaluated before any same-cycle pop. A push while full is dropped and sets tx_overflow, even if a pop occurs that cycle.
  - Push and pop in the same cycle on a non-empty, non-full FIFO leave the count unchanged and preserve order.
  - Push into an empty FIFO: tx_valid rises the next cycle, and there is no same-cycle pop.
  - Pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH and is held in log2(FIFO_DEPTH)+1 bits.
- tx_data and tx_valid come straight from FIFO state; there is no combinational path from tx_ready to tx_valid.
- Reset (asynchronous, any time, including mid-transfer):
  - mtime=0, MTIMECMP=0xFFFF_FFFF, irq_pending=0, tx_overflow=0.
  - FIFO pointers and count = 0, so tx_valid=0, tx_data=0, timer_irq=0.
  - RAM and FIFO storage contents are not reset.
  - ReadData follows decode; after reset, MTIME reads return 0 and STATUS reads 0x0000_0004.

Decomposition:
- Package dmem_pkg:
  - Region constants: RAM_REGION=4'h0, MMIO_REGION=4'h4.
  - MMIO offset constants: OFF_MTIME_LO, OFF_MTIME_HI, OFF_MTIMECMP, OFF_STATUS, OFF_TXDATA.
  - STATUS bit index constants.
  - MTIMECMP reset value.
- One sub-module, tx_fifo: synchronous FIFO parameterised by width 8 and FIFO_DEPTH, with push, pop, full, empty, count and overflow-on-push-when-full outputs. Decode, RAM and timer stay in the top module.

Test Plan:
- RAM round trip: store 0xDEADBEEF to 0x0000_0010, then load the same address next cycle, expecting 0xDEADBEEF. Load 0x0000_0110 (aliases with RAM_WORDS=64), expecting 0xDEADBEEF. Load 0x8000_0000, expecting 0.
- Timer/irq:
  - After reset, write MTIMECMP=20; read MTIME_LO, expecting it to have advanced by 1 per cycle.
  - Expect timer_irq to rise on the edge where mtime[31:0]==20 and stay high.
  - Write STATUS=0x1 and expect timer_irq to fall.
  - Clear it on the cycle mtime==MTIMECMP and expect it to stay high.
- FIFO fill/drain: with tx_ready=0, push 0x41,0x42,0x43,0x44.
  - Expect STATUS=0x0000_0042 (count 4, full).
  - Push 0x45: dropped, STATUS[3]=1.
  - Raise tx_ready: tx_data sequence 0x41..0x44, then tx_valid=0 and STATUS[2]=1.
- Simultaneous push/pop: with 2 entries and tx_ready=1, push 0x55 each cycle for 5 cycles. Expect count to stay 2 and output order to be preserved. Push while full with tx_ready=1: dropped and overflow set.
- Async reset mid-operation: assert reset between clock edges with the FIFO holding 3 entries and irq pending. Expect tx_valid, timer_irq and MTIME_LO at 0 immediately, MTIMECMP reading 0xFFFF_FFFF, and earlier RAM contents still readable.
